// File: rtl/rgbw_fifo_drain.sv
// rgbw_fifo_drain: sole reader of the RGB FIFO. It pops one pixel at a time, extracts white
// (W = min(R,G,B), subtracted from each colour), and offers {R',G',B',W} to the LED serializer
// over a valid/ready handshake. Only one pixel is ever in flight.
//
// Ports:
//   r_clk, r_rst_n   clock; synchronous active-low reset
//   fifo_r_data      FIFO read data, pixel in bits [23:0] as {R,G,B}
//   fifo_r_empty     FIFO empty flag (looked at only in idle)
//   fifo_r_en        FIFO pop strobe, one cycle per pixel
//   o_data/o_valid   RGBW word and its valid flag
//   o_ready          downstream accept
//   bypass           (RGBW_BYPASS_EN only) pass {R,G,B,8'h00} without white extraction
//   px_count         pixels accepted downstream, wraps
//   busy             high whenever a pixel is being processed
//
// Build option: define RGBW_BYPASS_EN to add the 'bypass' input.

module rgbw_fifo_drain #(
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  input  logic [DATA_SIZE-1:0] fifo_r_data,
  input  logic                 fifo_r_empty,
  output logic                 fifo_r_en,
  output logic [31:0]          o_data,
  output logic                 o_valid,
  input  logic                 o_ready,
`ifdef RGBW_BYPASS_EN
  input  logic                 bypass,
`endif
  output logic [CNT_W-1:0]     px_count,
  output logic                 busy
);

  typedef enum logic [2:0] {StIdle, StPop, StWait, StCalc, StOut} state_e;

  state_e            state_q, state_d;
  logic              fifo_r_en_d;
  logic [23:0]       pix_q, pix_d;
  logic [31:0]       data_d;
  logic              valid_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [7:0]        r, g, b, w, w_rg;

  // Bits above the pixel are don't-care.
  logic unused_hi;
  assign unused_hi = ^fifo_r_data[DATA_SIZE-1:24];

  assign r    = pix_q[23:16];
  assign g    = pix_q[15:8];
  assign b    = pix_q[7:0];
  assign w_rg = (r < g) ? r : g;
  assign w    = (w_rg < b) ? w_rg : b;

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    data_d  = o_data;
    valid_d = o_valid;
    cnt_d   = px_count;
    unique case (state_q)
      StIdle: begin
        if (!fifo_r_empty) state_d = StPop;
      end
      StPop: begin
        if (RD_LATENCY == 0) begin
          pix_d   = fifo_r_data[23:0];
          state_d = StCalc;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        pix_d   = fifo_r_data[23:0];
        state_d = StCalc;
      end
      StCalc: begin
        data_d  = {r - w, g - w, b - w, w};
`ifdef RGBW_BYPASS_EN
        if (bypass) data_d = {r, g, b, 8'h00};
`endif
        valid_d = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        if (o_ready) begin
          valid_d = 1'b0;
          cnt_d   = px_count + CNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered strobe: high exactly while the FSM sits in StPop.
    fifo_r_en_d = (state_d == StPop);
  end

  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      state_q   <= StIdle;
      fifo_r_en <= 1'b0;
      pix_q     <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      px_count  <= '0;
    end else begin
      state_q   <= state_d;
      fifo_r_en <= fifo_r_en_d;
      pix_q     <= pix_d;
      o_data    <= data_d;
      o_valid   <= valid_d;
      px_count  <= cnt_d;
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_rgbw_fifo_drain.sv
// Directed bench for rgbw_fifo_drain. A queue models the FIFO (registered read, one cycle
// latency). A second instance with a 3-bit counter shares all inputs and checks wrap-around.
module tb_rgbw_fifo_drain;

  localparam int RdLat = 1;

  logic        r_clk = 1'b0;
  logic        r_rst_n;
  logic [31:0] fifo_r_data;
  logic        fifo_r_empty;
  logic        o_ready;
  logic        fifo_r_en, o_valid, busy;
  logic [31:0] o_data;
  logic [15:0] px_count;
  logic        fifo_r_en_w, o_valid_w, busy_w;
  logic [31:0] o_data_w;
  logic [2:0]  px_count_w;
`ifdef RGBW_BYPASS_EN
  logic        bypass;
`endif

  always #5 r_clk = ~r_clk;

  rgbw_fifo_drain #(.DATA_SIZE(32), .RD_LATENCY(RdLat), .CNT_W(16)) u_dut (
    .r_clk        (r_clk),
    .r_rst_n      (r_rst_n),
    .fifo_r_data  (fifo_r_data),
    .fifo_r_empty (fifo_r_empty),
    .fifo_r_en    (fifo_r_en),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
`ifdef RGBW_BYPASS_EN
    .bypass       (bypass),
`endif
    .px_count     (px_count),
    .busy         (busy)
  );

  rgbw_fifo_drain #(.DATA_SIZE(32), .RD_LATENCY(RdLat), .CNT_W(3)) u_dut_wrap (
    .r_clk        (r_clk),
    .r_rst_n      (r_rst_n),
    .fifo_r_data  (fifo_r_data),
    .fifo_r_empty (fifo_r_empty),
    .fifo_r_en    (fifo_r_en_w),
    .o_data       (o_data_w),
    .o_valid      (o_valid_w),
    .o_ready      (o_ready),
`ifdef RGBW_BYPASS_EN
    .bypass       (bypass),
`endif
    .px_count     (px_count_w),
    .busy         (busy_w)
  );

  logic [31:0] fifo_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pops     = 0;
  int exp_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: the FIFO pops on the edge that ends a cycle with fifo_r_en high.
  task automatic tick();
    logic en_s;
    en_s = fifo_r_en;
    @(posedge r_clk);
    #1;
    cyc++;
    if (en_s === 1'b1) begin
      pops++;
      if (fifo_q.size() > 0) fifo_r_data = fifo_q.pop_front();
      fifo_r_empty = (fifo_q.size() == 0);
    end
  endtask

  task automatic push(input logic [31:0] word);
    fifo_q.push_back(word);
    fifo_r_empty = 1'b0;
  endtask

  // Waits for o_valid, checks the word and latency; accepts it if o_ready is high.
  task automatic get_pixel(input string tag, input logic [31:0] exp);
    int en_at;
    int en_n;
    bit seen;
    en_at = -100;
    en_n  = 0;
    seen  = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (fifo_r_en === 1'b1) begin
        en_at = cyc;
        en_n++;
      end
      if (o_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_data"}, o_data, exp);
    check({tag, "_en_pulses"}, 32'(en_n), 32'd1);
    check({tag, "_latency"}, 32'(cyc - en_at), 32'(RdLat + 2));
    if (o_ready) begin
      tick();
      exp_cnt++;
      check({tag, "_vdrop"}, 32'(o_valid), 32'd0);
      check({tag, "_count"}, 32'(px_count), 32'(exp_cnt % 65536));
    end
  endtask

  logic [31:0] vin[7]  = '{32'h00010203, 32'h00102030, 32'h00FFFFFF, 32'h00000001,
                           32'h00FF00FF, 32'h12345678, 32'h00C8C864};
  logic [31:0] vexp[7] = '{32'h00010201, 32'h00102010, 32'h000000FF, 32'h00000100,
                           32'hFF00FF00, 32'h00224434, 32'h64640064};

  initial begin
    int en_seen;
    int pops0;
    logic [31:0] held;
    r_rst_n      = 1'b0;
    fifo_r_empty = 1'b1;
    fifo_r_data  = '0;
    o_ready      = 1'b1;
`ifdef RGBW_BYPASS_EN
    bypass       = 1'b0;
`endif

    // Reset, then idle with an empty FIFO.
    tick();
    tick();
    r_rst_n = 1'b1;
    en_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fifo_r_en !== 1'b0) en_seen++;
    end
    check("idle_en", 32'(en_seen), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(px_count), 32'd0);

    // Single pixel.
    push(32'h00FF8040);
    get_pixel("px1", 32'hBF400040);

    // Back-to-back pixels.
    push(32'h00808080);
    push(32'h000000FF);
    push(32'hAB000000);
    get_pixel("grey", 32'h00000080);
    get_pixel("blue", 32'h0000FF00);
    get_pixel("black", 32'h00000000);

    // Back-pressure: hold in OUT with a word still waiting in the FIFO.
    o_ready = 1'b0;
    push(32'h00FF8040);
    push(32'h00102030);
    get_pixel("bp", 32'hBF400040);
    held = o_data;
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fifo_r_en !== 1'b0 || o_valid !== 1'b1 || o_data !== held || fifo_q.size() != 1)
        en_seen++;
    end
    check("bp_hold", 32'(en_seen), 32'd0);
    check("bp_level", 32'(fifo_q.size()), 32'd1);
    check("bp_count_held", 32'(px_count), 32'(exp_cnt));
    o_ready = 1'b1;
    tick();
    exp_cnt++;
    check("bp_accept_valid", 32'(o_valid), 32'd0);
    check("bp_accept_count", 32'(px_count), 32'(exp_cnt));
    get_pixel("bp_next", 32'h00102010);

    // Reset while waiting for read data.
    push(32'h00FFFFFF);
    for (int i = 0; i < 10 && fifo_r_en !== 1'b1; i++) tick();
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    r_rst_n = 1'b0;
    tick();
    r_rst_n = 1'b1;
    exp_cnt = 0;
    check("mid_valid", 32'(o_valid), 32'd0);
    check("mid_data", o_data, 32'd0);
    check("mid_busy0", 32'(busy), 32'd0);
    check("mid_count", 32'(px_count), 32'd0);
    pops0 = pops;
    for (int i = 0; i < 5; i++) tick();
    check("mid_no_repop", 32'(pops), 32'(pops0));
    check("mid_no_out", 32'(o_valid), 32'd0);
    push(32'h00FF8040);
    get_pixel("post_rst", 32'hBF400040);

    // Seven more pixels: 8 total since reset wraps the 3-bit counter to 0.
    for (int i = 0; i < 7; i++) begin
      push(vin[i]);
      get_pixel($sformatf("vec%0d", i), vexp[i]);
    end
    check("wrap_main", 32'(px_count), 32'd8);
    check("wrap_small", 32'(px_count_w), 32'd0);

`ifdef RGBW_BYPASS_EN
    bypass = 1'b1;
    push(32'h00FF8040);
    get_pixel("bypass", 32'hFF804000);
    bypass = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
